// File: rtl/qspi_target_ram.sv
// QSPI target backed by an internal byte array (quad cmd/addr/data, 0x0B read, 0x02 write).
// Optional QSPI_TARGET_BACKDOOR_EN adds a clk-domain preload port.
module qspi_target_ram #(
  parameter int ADDR_BITS    = 8,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef QSPI_TARGET_BACKDOOR_EN
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
`endif
  input  logic                 qspi_clk,
  input  logic                 qspi_select_n,
  input  logic [3:0]           qspi_data_in,
  output logic [3:0]           qspi_data_out,
  output logic [3:0]           qspi_data_oe,
  output logic                 busy
);
  localparam int DW = $clog2(DUMMY_CYCLES + 2);
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

  logic [1:0]           sck_sync_reg;
  logic [1:0]           sel_sync_reg;
  logic [3:0]           din_sync0_reg;
  logic [3:0]           din_sync1_reg;
  logic                 sck_d_reg;
  state_t               state_reg;
  logic [2:0]           nib_cnt_reg;
  logic [3:0]           cmd_hi_reg;
  logic                 is_write_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DW-1:0]        dummy_cnt_reg;
  logic                 nib_low_reg;
  logic [3:0]           wr_hi_reg;
  logic                 oe_reg;
  logic [7:0]           rd_byte_reg;
  logic [7:0]           mem [0:(1<<ADDR_BITS)-1];

  logic       sck_s;
  logic       sel_n_s;
  logic [3:0] din_s;
  logic       sck_rise;
  logic       sck_fall;
  logic       wr_en;

  assign sck_s    = sck_sync_reg[1];
  assign sel_n_s  = sel_sync_reg[1];
  assign din_s    = din_sync1_reg;
  assign sck_rise = sck_s & ~sck_d_reg;
  assign sck_fall = ~sck_s & sck_d_reg;
  assign wr_en    = (state_reg == WDATA) && sck_rise && nib_low_reg && !sel_n_s;
  assign qspi_data_oe = {4{oe_reg}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_reg  <= 2'b00;
      sel_sync_reg  <= 2'b11;
      din_sync0_reg <= 4'h0;
      din_sync1_reg <= 4'h0;
      sck_d_reg     <= 1'b0;
      state_reg     <= IDLE;
      nib_cnt_reg   <= 3'd0;
      cmd_hi_reg    <= 4'h0;
      is_write_reg  <= 1'b0;
      addr_reg      <= '0;
      dummy_cnt_reg <= '0;
      nib_low_reg   <= 1'b0;
      wr_hi_reg     <= 4'h0;
      oe_reg        <= 1'b0;
      qspi_data_out <= 4'h0;
      busy          <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[0], qspi_clk};
      sel_sync_reg  <= {sel_sync_reg[0], qspi_select_n};
      din_sync0_reg <= qspi_data_in;
      din_sync1_reg <= din_sync0_reg;
      sck_d_reg     <= sck_s;
      // Deselect overrides every state; a half-received write byte is simply dropped.
      if (sel_n_s) begin
        state_reg     <= IDLE;
        oe_reg        <= 1'b0;
        qspi_data_out <= 4'h0;
        busy          <= 1'b0;
        nib_low_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= CMD;
            busy        <= 1'b1;
            nib_cnt_reg <= 3'd0;
            nib_low_reg <= 1'b0;
          end
          CMD: if (sck_rise) begin
            cmd_hi_reg <= din_s;
            if (nib_cnt_reg == 3'd1) begin
              nib_cnt_reg <= 3'd0;
              case ({cmd_hi_reg, din_s})
                CMD_READ:  begin state_reg <= ADDR; is_write_reg <= 1'b0; end
                CMD_WRITE: begin state_reg <= ADDR; is_write_reg <= 1'b1; end
                default:   state_reg <= IGNORE;
              endcase
            end else begin
              nib_cnt_reg <= nib_cnt_reg + 3'd1;
            end
          end
          ADDR: if (sck_rise) begin
            // Shifting through ADDR_BITS keeps only the low bits of the 24-bit address.
            addr_reg <= ADDR_BITS'({addr_reg, din_s});
            if (nib_cnt_reg == 3'd5) begin
              nib_cnt_reg   <= 3'd0;
              dummy_cnt_reg <= '0;
              nib_low_reg   <= 1'b0;
              state_reg     <= is_write_reg ? WDATA : DUMMY;
            end else begin
              nib_cnt_reg <= nib_cnt_reg + 3'd1;
            end
          end
          DUMMY: begin
            if (sck_fall && dummy_cnt_reg == DW'(DUMMY_CYCLES)) begin
              qspi_data_out <= rd_byte_reg[7:4];
              oe_reg        <= 1'b1;
              nib_low_reg   <= 1'b1;
              state_reg     <= RDATA;
            end else if (sck_rise && dummy_cnt_reg != DW'(DUMMY_CYCLES)) begin
              dummy_cnt_reg <= dummy_cnt_reg + 1'b1;
            end
          end
          RDATA: if (sck_fall) begin
            if (nib_low_reg) begin
              qspi_data_out <= rd_byte_reg[3:0];
              addr_reg      <= addr_reg + 1'b1;
              nib_low_reg   <= 1'b0;
            end else begin
              qspi_data_out <= rd_byte_reg[7:4];
              nib_low_reg   <= 1'b1;
            end
          end
          WDATA: if (sck_rise) begin
            if (nib_low_reg) begin
              addr_reg    <= addr_reg + 1'b1;
              nib_low_reg <= 1'b0;
            end else begin
              wr_hi_reg   <= din_s;
              nib_low_reg <= 1'b1;
            end
          end
          IGNORE: oe_reg <= 1'b0;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Registered read has several clk cycles of slack before the next SCK fall.
  always_ff @(posedge clk) begin
`ifdef QSPI_TARGET_BACKDOOR_EN
    if (load_en) mem[load_addr] <= load_data;
`endif
    if (wr_en) mem[addr_reg] <= {wr_hi_reg, din_s};
    rd_byte_reg <= mem[addr_reg];
  end

endmodule

// File: tb/tb_qspi_target_ram.sv
// Bench for qspi_target_ram: directed table, corner sequences and random traffic vs. a byte-array model.
module tb_qspi_target_ram;
  localparam int ADDR_BITS = 8;
  localparam int DUMMY     = 4;
  localparam int MEM_SIZE  = 1 << ADDR_BITS;
  localparam time HALF     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic qspi_clk = 1'b0;
  logic qspi_select_n = 1'b1;
  logic [3:0] qspi_data_in = 4'h0;
  logic [3:0] qspi_data_out;
  logic [3:0] qspi_data_oe;
  logic busy;
`ifdef QSPI_TARGET_BACKDOOR_EN
  logic                 load_en = 1'b0;
  logic [ADDR_BITS-1:0] load_addr = '0;
  logic [7:0]           load_data = 8'h00;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] model_mem [MEM_SIZE];
  logic [7:0] rd_q [$];

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    int          n;
    logic [31:0] data;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  qspi_target_ram #(.ADDR_BITS(ADDR_BITS), .DUMMY_CYCLES(DUMMY)) dut (
    .clk(clk),
    .rst(rst),
`ifdef QSPI_TARGET_BACKDOOR_EN
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
`endif
    .qspi_clk(qspi_clk),
    .qspi_select_n(qspi_select_n),
    .qspi_data_in(qspi_data_in),
    .qspi_data_out(qspi_data_out),
    .qspi_data_oe(qspi_data_oe),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int midx(input logic [23:0] a, input int i);
    return (int'(a[ADDR_BITS-1:0]) + i) % MEM_SIZE;
  endfunction

  // One SCK period: data set while low, rise, sample target output just before the fall.
  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    qspi_data_in = d;
    #HALF qspi_clk = 1'b1;
    #HALF;
    q  = qspi_data_out;
    oe = qspi_data_oe;
    qspi_clk = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr, output bit oe_seen);
    logic [3:0] q;
    logic [3:0] oe;
    logic [31:0] hdr;
    hdr = {cmd, addr};
    oe_seen = 1'b0;
    qspi_select_n = 1'b0;
    #HALF;
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(hdr[i*4 +: 4], q, oe);
      if (oe != 4'h0) oe_seen = 1'b1;
    end
  endtask

  task automatic end_tx(input string tag);
    #HALF qspi_select_n = 1'b1;
    #30;
    check({tag, "_deselect"}, {27'd0, busy, qspi_data_oe}, 32'd0);
    #50;
  endtask

  task automatic read_tx(input string tag, input logic [23:0] addr, input int n);
    logic [3:0] q;
    logic [3:0] hi;
    logic [3:0] oe;
    bit bad_idle;
    bit bad_data;
    rd_q = {};
    send_header(8'h0B, addr, bad_idle);
    for (int i = 0; i < DUMMY; i++) begin
      sck_cycle(4'h0, q, oe);
      if (oe != 4'h0) bad_idle = 1'b1;
    end
    bad_data = 1'b0;
    for (int i = 0; i < n; i++) begin
      sck_cycle(4'h0, hi, oe);
      if (oe != 4'hF) bad_data = 1'b1;
      sck_cycle(4'h0, q, oe);
      if (oe != 4'hF) bad_data = 1'b1;
      rd_q.push_back({hi, q});
    end
    check({tag, "_oe_idle"}, 32'(bad_idle), 32'd0);
    check({tag, "_oe_data"}, 32'(bad_data), 32'd0);
    end_tx(tag);
    $display("xfer read  %s addr=%06h bytes=%0d", tag, addr, n);
  endtask

  task automatic read_cmp_model(input string tag, input logic [23:0] addr, input int n);
    read_tx(tag, addr, n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rd_q[i]), 32'(model_mem[midx(addr, i)]));
  endtask

  task automatic write_tx(input string tag, input logic [23:0] addr, input logic [7:0] bytes [$]);
    logic [3:0] q;
    logic [3:0] oe;
    bit bad;
    send_header(8'h02, addr, bad);
    foreach (bytes[i]) begin
      sck_cycle(bytes[i][7:4], q, oe);
      if (oe != 4'h0) bad = 1'b1;
      sck_cycle(bytes[i][3:0], q, oe);
      if (oe != 4'h0) bad = 1'b1;
      model_mem[midx(addr, i)] = bytes[i];
    end
    check({tag, "_oe_wr"}, 32'(bad), 32'd0);
    end_tx(tag);
    $display("xfer write %s addr=%06h bytes=%0d", tag, addr, bytes.size());
  endtask

  initial begin
    logic [7:0] bq [$];
    logic [3:0] q;
    logic [3:0] oe;
    logic [23:0] a;
    int n;
    bit bad;

    vecs[0] = '{1'b1, 24'h000010, 2, 32'hA53C_0000};
    vecs[1] = '{1'b0, 24'h000010, 2, 32'hA53C_0000};
    vecs[2] = '{1'b1, 24'h0000FF, 2, 32'h1122_0000};
    vecs[3] = '{1'b0, 24'h0000FF, 2, 32'h1122_0000};
    vecs[4] = '{1'b0, 24'h000000, 1, 32'h2200_0000};
    vecs[5] = '{1'b0, 24'hABCD10, 2, 32'hA53C_0000};
    vecs[6] = '{1'b1, 24'h000030, 4, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 24'h000031, 3, 32'hADBE_EF00};

    #20;
    check("reset_outputs", {23'd0, busy, qspi_data_oe, qspi_data_out}, 32'd0);
    rst = 1'b0;
    #50;

    // SCK activity while deselected must not wake the target.
    for (int i = 0; i < 4; i++) begin
      #HALF qspi_clk = 1'b1;
      #HALF qspi_clk = 1'b0;
    end
    check("desel_sck_busy", {27'd0, busy, qspi_data_oe}, 32'd0);

    // Fill every location so the model is fully known.
    bq = {};
    for (int i = 0; i < MEM_SIZE; i++) bq.push_back(8'($urandom));
    write_tx("fill", 24'h000000, bq);

    foreach (vecs[v]) begin
      if (vecs[v].wr) begin
        bq = {};
        for (int i = 0; i < vecs[v].n; i++) bq.push_back(vecs[v].data[31-8*i -: 8]);
        write_tx($sformatf("vec%0d", v), vecs[v].addr, bq);
      end else begin
        read_tx($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n);
        for (int i = 0; i < vecs[v].n; i++)
          check($sformatf("vec%0d_byte%0d", v, i), 32'(rd_q[i]), 32'(vecs[v].data[31-8*i -: 8]));
      end
    end

    // Unknown command: oe never asserts; busy drops on the third clk after deselect.
    send_header(8'h9F, 24'h000010, bad);
    sck_cycle(4'hA, q, oe);
    if (oe != 4'h0) bad = 1'b1;
    sck_cycle(4'hB, q, oe);
    if (oe != 4'h0) bad = 1'b1;
    check("unk_oe", 32'(bad), 32'd0);
    #HALF qspi_select_n = 1'b1;
    #20;
    check("unk_busy_2cyc", 32'(busy), 32'd1);
    #10;
    check("unk_busy_3cyc", {27'd0, busy, qspi_data_oe}, 32'd0);
    #50;
    $display("xfer cmd9F ignored");
    read_cmp_model("unk_nochange", 24'h000010, 4);

    // Aborted write: third nibble is dropped on deselect.
    send_header(8'h02, 24'h000020, bad);
    sck_cycle(4'h1, q, oe);
    sck_cycle(4'h2, q, oe);
    sck_cycle(4'h3, q, oe);
    end_tx("abort");
    $display("xfer write abort addr=000020 nibbles=3");
    model_mem[8'h20] = 8'h12;
    read_tx("abort_rd", 24'h000020, 2);
    check("abort_byte0", 32'(rd_q[0]), 32'h12);
    check("abort_byte1", 32'(rd_q[1]), 32'(model_mem[8'h21]));

    // Reset in the middle of a read data phase.
    send_header(8'h0B, 24'h000030, bad);
    for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0, q, oe);
    sck_cycle(4'h0, q, oe);
    check("rstmid_nib0", {28'd0, q}, 32'hD);
    check("rstmid_oe_pre", {28'd0, oe}, 32'hF);
    sck_cycle(4'h0, q, oe);
    rst = 1'b1;
    #1;
    check("rstmid_async", {23'd0, busy, qspi_data_oe, qspi_data_out}, 32'd0);
    #19 qspi_select_n = 1'b1;
    #20 rst = 1'b0;
    #50;
    $display("xfer read reset mid-transfer");
    read_cmp_model("rstmid_rd", 24'h000030, 4);

`ifdef QSPI_TARGET_BACKDOOR_EN
    load_en = 1'b1; load_addr = 8'h40; load_data = 8'hDE;
    #10 load_addr = 8'h41; load_data = 8'hAD;
    #10 load_en = 1'b0;
    model_mem[8'h40] = 8'hDE;
    model_mem[8'h41] = 8'hAD;
    $display("xfer backdoor load 40..41");
    read_tx("bdoor", 24'h000040, 2);
    check("bdoor_byte0", 32'(rd_q[0]), 32'hDE);
    check("bdoor_byte1", 32'(rd_q[1]), 32'hAD);
`endif

    // Random traffic against the byte-array model.
    for (int t = 0; t < 30; t++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        bq = {};
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
        write_tx($sformatf("rnd%0d", t), a, bq);
      end else begin
        read_cmp_model($sformatf("rnd%0d", t), a, n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
